// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction fetch stage.
//   IF_WIDTH     default datapath / address width
//   IF_RESET_PC  default address of the first fetch after reset
//   IF_PC_STEP   default byte increment between sequential instructions
//   IF_NOP       encoding presented to decode whenever no instruction is valid
//   fetch_state_t  control states of the fetch sequencer
// ----------------------------------------------------------------------------
package isa_pkg;

   localparam int          IF_WIDTH    = 32;
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_PC_STEP  = 32'd4;
   localparam logic [31:0] IF_NOP      = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_BOOT     = 2'd0,
      FETCH_RUN      = 2'd1,
      FETCH_STALL    = 2'd2,
      FETCH_REDIRECT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
// Single-entry holding register for an instruction that came back from memory
// while decode was stalled. Clear has priority over load.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   load_i           capture instr_i / pc_i and mark the entry valid
//   clear_i          drop the entry
//   instr_i, pc_i    data to capture
//   instr_o, pc_o    stored entry
//   valid_o          entry holds a real instruction
// ----------------------------------------------------------------------------
module fetch_skid_buffer
   import isa_pkg::*;
#(
   parameter int WIDTH = IF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] instr_i,
   input  logic [WIDTH-1:0] pc_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] pc_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] skid_instr_q;
   logic [WIDTH-1:0] skid_pc_q;
   logic             skid_vld_q;

   // Entry storage. A clear always wins so that a redirect arriving together
   // with a capture can never leave stale data behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_vld_q   <= 1'b0;
      end else if (clear_i) begin
         skid_vld_q   <= 1'b0;
      end else if (load_i) begin
         skid_instr_q <= instr_i;
         skid_pc_q    <= pc_i;
         skid_vld_q   <= 1'b1;
      end
   end

   assign instr_o = skid_instr_q;
   assign pc_o    = skid_pc_q;
   assign valid_o = skid_vld_q;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Front-end fetch stage: drives the instruction memory address, pairs the
// returned word with its address and hands it to decode. Handles decode
// back-pressure with a one-entry skid buffer and execute redirects with a
// fixed two-bubble penalty.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   stall_i           decode cannot accept; hold outputs
//   branch_i          one-cycle redirect request
//   branch_target_i   redirect address
//   imem_addr_o       instruction memory address (next fetch, pc_q)
//   imem_rdata_i      memory data, one cycle after its address
//   instr_o, pc_o     instruction to decode and its address
//   valid_o           instr_o / pc_o hold a real instruction
// ----------------------------------------------------------------------------
module instruction_fetch
   import isa_pkg::*;
#(
   parameter int               WIDTH    = IF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC),
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(IF_PC_STEP)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic [WIDTH-1:0] branch_target_i,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic [WIDTH-1:0] imem_rdata_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] pc_o,
   output logic             valid_o
);

   localparam logic [WIDTH-1:0] NopWord = WIDTH'(IF_NOP);

   fetch_state_t     state_q, state_d;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] req_pc_q, req_pc_d;
   logic             req_vld_q, req_vld_d;

   logic [WIDTH-1:0] out_instr_q, out_instr_d;
   logic [WIDTH-1:0] out_pc_q, out_pc_d;
   logic             out_vld_q, out_vld_d;

   logic             skid_load;
   logic             skid_clear;
   logic [WIDTH-1:0] skid_instr;
   logic [WIDTH-1:0] skid_pc;
   logic             skid_vld;

   // Holds the word that was in flight when decode stalled, so that the
   // memory port can be left idle without losing that instruction.
   fetch_skid_buffer #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .instr_i (imem_rdata_i),
      .pc_i    (req_pc_q),
      .instr_o (skid_instr),
      .pc_o    (skid_pc),
      .valid_o (skid_vld)
   );

   // State register. Reset always returns to BOOT so the first fetch is
   // re-issued from RESET_PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection is the same from every state: a redirect beats a
   // stall, and otherwise the sequencer runs.
   always_comb begin
      state_d = FETCH_RUN;
      if (branch_i) begin
         state_d = FETCH_REDIRECT;
      end else if (stall_i) begin
         state_d = FETCH_STALL;
      end
   end

   // Per-state datapath updates. BOOT and REDIRECT issue the first fetch of a
   // new stream and present a bubble; RUN/STALL either advance the stream or
   // freeze it, parking the in-flight word in the skid buffer on a stall.
   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_vld_d   = req_vld_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      out_vld_d   = out_vld_q;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;

      if (branch_i) begin
         pc_d        = branch_target_i;
         req_vld_d   = 1'b0;
         skid_clear  = 1'b1;
         out_vld_d   = 1'b0;
         out_instr_d = NopWord;
      end else begin
         unique case (state_q)
            FETCH_BOOT: begin
               out_vld_d   = 1'b0;
               out_instr_d = NopWord;
               req_pc_d    = RESET_PC;
               req_vld_d   = 1'b1;
               pc_d        = RESET_PC + PC_STEP;
            end
            FETCH_REDIRECT: begin
               out_vld_d   = 1'b0;
               out_instr_d = NopWord;
               req_pc_d    = pc_q;
               req_vld_d   = 1'b1;
               pc_d        = pc_q + PC_STEP;
            end
            FETCH_RUN, FETCH_STALL: begin
               if (stall_i) begin
                  if (req_vld_q && !skid_vld) begin
                     skid_load = 1'b1;
                  end
                  req_vld_d = 1'b0;
               end else begin
                  if (skid_vld) begin
                     out_instr_d = skid_instr;
                     out_pc_d    = skid_pc;
                     out_vld_d   = 1'b1;
                  end else begin
                     out_instr_d = req_vld_q ? imem_rdata_i : NopWord;
                     out_pc_d    = req_pc_q;
                     out_vld_d   = req_vld_q;
                  end
                  skid_clear = 1'b1;
                  req_pc_d   = pc_q;
                  req_vld_d  = 1'b1;
                  pc_d       = pc_q + PC_STEP;
               end
            end
            default: begin
               out_vld_d   = 1'b0;
               out_instr_d = NopWord;
            end
         endcase
      end
   end

   // Fetch pointer, outstanding-request tracking and decode-facing outputs.
   // Reset drops everything in flight; pc_o clears to zero, not RESET_PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         req_pc_q    <= '0;
         req_vld_q   <= 1'b0;
         out_instr_q <= NopWord;
         out_pc_q    <= '0;
         out_vld_q   <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_vld_q   <= req_vld_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         out_vld_q   <= out_vld_d;
      end
   end

   assign imem_addr_o = pc_q;
   assign instr_o     = out_instr_q;
   assign pc_o        = out_pc_q;
   assign valid_o     = out_vld_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The instruction memory returns
// mem[a] = a + 0x100 one cycle after address a.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch;
   logic [31:0] branchTarget;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata = 32'h0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;

   int checkCount = 0;
   int errorCount = 0;

   instruction_fetch #(
      .WIDTH    (32),
      .RESET_PC (32'h0),
      .PC_STEP  (32'd4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall_i         (stall),
      .branch_i        (branch),
      .branch_target_i (branchTarget),
      .imem_addr_o     (imemAddr),
      .imem_rdata_i    (imemRdata),
      .instr_o         (instr),
      .pc_o            (pc),
      .valid_o         (valid)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory with a fixed content pattern.
   always @(posedge clk) begin
      imemRdata <= imemAddr + 32'h100;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and move to just after the next rising edge.
   task automatic applyStimulus(input logic s, input logic b, input logic [31:0] tgt);
      stall        = s;
      branch       = b;
      branchTarget = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic checkValid(input string tag, input logic [31:0] expPc,
                             input logic [31:0] expInstr);
      checkOutput({tag, ".valid"}, {31'b0, valid}, 32'd1);
      checkOutput({tag, ".pc"}, pc, expPc);
      checkOutput({tag, ".instr"}, instr, expInstr);
   endtask

   task automatic checkBubble(input string tag);
      checkOutput({tag, ".valid"}, {31'b0, valid}, 32'd0);
      checkOutput({tag, ".instr"}, instr, 32'h0);
   endtask

   // Directed scenario walk-through.
   initial begin
      rst_n        = 1'b0;
      stall        = 1'b0;
      branch       = 1'b0;
      branchTarget = 32'h0;

      #3;
      checkBubble("reset");
      checkOutput("reset.pc", pc, 32'h0);
      checkOutput("reset.addr", imemAddr, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b0, 1'b0, 32'h0);
      checkBubble("boot");
      checkOutput("boot.addr", imemAddr, 32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("run0", 32'h0, 32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("run4", 32'h4, 32'h104);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkValid("stallHold", 32'h4, 32'h104);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("release8", 32'h8, 32'h108);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("release12", 32'hC, 32'h10C);

      applyStimulus(1'b0, 1'b1, 32'h40);
      checkBubble("branchBubble1");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkBubble("branchBubble2");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("branchTarget", 32'h40, 32'h140);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("branchNext", 32'h44, 32'h144);

      applyStimulus(1'b1, 1'b0, 32'h0);
      checkValid("stallBeforeBranch", 32'h44, 32'h144);
      applyStimulus(1'b1, 1'b1, 32'h80);
      checkBubble("branchStallBubble1");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkBubble("branchStallBubble2");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("branchStallTarget", 32'h80, 32'h180);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("branchStallNext", 32'h84, 32'h184);

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrapAddrTop", imemAddr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("wrapAddrZero", imemAddr, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("wrapTop", 32'hFFFF_FFFC, 32'h0000_00FC);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("wrapZero", 32'h0, 32'h100);

      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkValid("stallBeforeReset", 32'h0, 32'h100);
      #2;
      rst_n = 1'b0;
      stall = 1'b0;
      #1;
      checkBubble("asyncReset");
      checkOutput("asyncReset.addr", imemAddr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(1'b0, 1'b0, 32'h0);
      checkBubble("reboot");
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("restart0", 32'h0, 32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("restart4", 32'h4, 32'h104);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkValid("restart8", 32'h8, 32'h108);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
